// File: rtl/window_fetch_controller.sv
// Sliding-window producer: fills a (SIZE+1)^2 pixel buffer from frame memory,
// walks the image in serpentine order and refetches only the exposed edge per move.
//
// state     | meaning
// IDLE      | waiting for start
// FILL_REQ  | issue one read of the initial fill
// FILL_WAIT | wait for read data of the initial fill
// PRESENT   | one-cycle done pulse, window valid
// HOLD      | wait for kernel_done
// SHIFT     | move origin, shift buffer by one pixel
// EDGE_REQ  | issue one read of the exposed edge
// EDGE_WAIT | wait for read data of the exposed edge
// FINISH    | one-cycle frame_done pulse
module window_fetch_controller #(
    parameter int SIZE   = 3,
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16,
    parameter int ADDR_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       kernel_done,
    output logic                       mem_req,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic [7:0]                 mem_rdata,
    input  logic                       mem_rvalid,
    output logic [SIZE:0][SIZE:0][7:0] input_buffer,
    output logic                       done,
    output logic [1:0]                 next_dir,
    output logic                       busy,
    output logic                       frame_done
);

    localparam int IW = $clog2(SIZE + 1);
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam logic [IW-1:0] LAST_IDX = IW'(SIZE);

    localparam logic [1:0] MV_RIGHT = 2'b00;
    localparam logic [1:0] MV_LEFT  = 2'b01;
    localparam logic [1:0] MV_DOWN  = 2'b10;

    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] FILL_REQ  = 4'd1;
    localparam logic [3:0] FILL_WAIT = 4'd2;
    localparam logic [3:0] PRESENT   = 4'd3;
    localparam logic [3:0] HOLD      = 4'd4;
    localparam logic [3:0] SHIFT     = 4'd5;
    localparam logic [3:0] EDGE_REQ  = 4'd6;
    localparam logic [3:0] EDGE_WAIT = 4'd7;
    localparam logic [3:0] FINISH    = 4'd8;

    logic [3:0]        state;
    logic [RW-1:0]     r;
    logic [CW-1:0]     c;
    logic              pass_left;
    logic [IW-1:0]     ix;
    logic [IW-1:0]     iy;
    logic [IW-1:0]     cnt;
    logic [1:0]        move;
    logic              at_right_end;
    logic              at_left_end;
    logic              last_win;
    logic [ADDR_W-1:0] addr_calc;

    assign at_right_end = (c == CW'(IMG_W - SIZE - 1));
    assign at_left_end  = (c == '0);
    assign last_win     = (r == RW'(IMG_H - SIZE - 1)) && (pass_left ? at_left_end : at_right_end);

    always_comb begin
        move = MV_DOWN;
        if (!pass_left && !at_right_end)
            move = MV_RIGHT;
        else if (pass_left && !at_left_end)
            move = MV_LEFT;
    end

    // ix/iy address the buffer slot being filled, so they also locate the image pixel
    assign addr_calc  = (ADDR_W'(r) + ADDR_W'(iy)) * ADDR_W'(IMG_W) + ADDR_W'(c) + ADDR_W'(ix);
    assign mem_req    = (state == FILL_REQ) || (state == EDGE_REQ);
    assign mem_addr   = mem_req ? addr_calc : '0;
    assign done       = (state == PRESENT);
    assign frame_done = (state == FINISH);
    assign busy       = (state != IDLE) && (state != FINISH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            r            <= '0;
            c            <= '0;
            pass_left    <= 1'b0;
            ix           <= '0;
            iy           <= '0;
            cnt          <= '0;
            input_buffer <= '0;
            next_dir     <= MV_RIGHT;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ix    <= '0;
                        iy    <= '0;
                        state <= FILL_REQ;
                    end
                end
                FILL_REQ: state <= FILL_WAIT;
                FILL_WAIT: begin
                    if (mem_rvalid) begin
                        input_buffer[ix][iy] <= mem_rdata;
                        if (ix == LAST_IDX) begin
                            ix <= '0;
                            if (iy == LAST_IDX) begin
                                iy       <= '0;
                                next_dir <= MV_LEFT;
                                state    <= PRESENT;
                            end else begin
                                iy    <= iy + 1'b1;
                                state <= FILL_REQ;
                            end
                        end else begin
                            ix    <= ix + 1'b1;
                            state <= FILL_REQ;
                        end
                    end
                end
                PRESENT: state <= HOLD;
                HOLD: begin
                    if (kernel_done)
                        state <= last_win ? FINISH : SHIFT;
                end
                SHIFT: begin
                    next_dir <= move;
                    cnt      <= '0;
                    state    <= EDGE_REQ;
                    case (move)
                        MV_RIGHT: begin
                            c  <= c + 1'b1;
                            ix <= LAST_IDX;
                            iy <= '0;
                            for (int x = 0; x < SIZE; x++)
                                input_buffer[x] <= input_buffer[x+1];
                        end
                        MV_LEFT: begin
                            c  <= c - 1'b1;
                            ix <= '0;
                            iy <= '0;
                            for (int x = 0; x < SIZE; x++)
                                input_buffer[x+1] <= input_buffer[x];
                        end
                        default: begin
                            r         <= r + 1'b1;
                            pass_left <= !pass_left;
                            ix        <= '0;
                            iy        <= LAST_IDX;
                            for (int x = 0; x <= SIZE; x++)
                                for (int y = 0; y < SIZE; y++)
                                    input_buffer[x][y] <= input_buffer[x][y+1];
                        end
                    endcase
                end
                EDGE_REQ: state <= EDGE_WAIT;
                EDGE_WAIT: begin
                    if (mem_rvalid) begin
                        input_buffer[ix][iy] <= mem_rdata;
                        if (cnt == LAST_IDX) begin
                            state <= PRESENT;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= EDGE_REQ;
                            if (next_dir == MV_DOWN)
                                ix <= ix + 1'b1;
                            else
                                iy <= iy + 1'b1;
                        end
                    end
                end
                FINISH: begin
                    r         <= '0;
                    c         <= '0;
                    pass_left <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
